// File: rtl/huff_pkg.sv
// Shared Huffman definitions: symbol range, code table and serializer states.
// The encoder and the decoder bench both import this package.
package huff_pkg;

    localparam int SYM_W  = 3;
    localparam int CODE_W = 4;
    localparam int LEN_W  = 2;

    localparam logic [SYM_W-1:0] SYM_MIN = 3'd1;
    localparam logic [SYM_W-1:0] SYM_MAX = 3'd6;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_t;

    function automatic logic sym_is_legal(input logic [SYM_W-1:0] sym);
        return (sym >= SYM_MIN) && (sym <= SYM_MAX);
    endfunction

    // Codes are left-aligned so the serializer always shifts out bit 3 first
    function automatic logic [CODE_W-1:0] code_bits(input logic [SYM_W-1:0] sym);
        logic [CODE_W-1:0] bits;
        case (sym)
            3'd1:    bits = 4'b0000;
            3'd2:    bits = 4'b1010;
            3'd3:    bits = 4'b1000;
            3'd4:    bits = 4'b1110;
            3'd5:    bits = 4'b1101;
            3'd6:    bits = 4'b1100;
            default: bits = 4'b0000;
        endcase
        return bits;
    endfunction

    // Code length minus one, which is what the remaining-bit counter loads
    function automatic logic [LEN_W-1:0] code_last(input logic [SYM_W-1:0] sym);
        logic [LEN_W-1:0] last;
        case (sym)
            3'd1:                 last = 2'd0;
            3'd2, 3'd3, 3'd4:     last = 2'd2;
            3'd5, 3'd6:           last = 2'd3;
            default:              last = 2'd0;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/huffman_encoder_sym_fifo.sv
// Small symbol FIFO sitting in front of the Huffman serializer.
// Read data is always the oldest entry, so a pop consumes pop_data directly.
module sym_fifo
    import huff_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [SYM_W-1:0] push_data,
    input  logic             pop,
    output logic [SYM_W-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [SYM_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/huffman_encoder.sv
// Huffman encoder: buffers symbols in sym_fifo and serializes their codes
// MSB first on x, back to back with no idle cycle between codes.
module huffman_encoder
    import huff_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SYM_W-1:0] sym_in,
    input  logic             sym_valid,
    output logic             sym_ready,
    output logic             x,
    output logic             x_valid,
    output logic             err,
    output logic             busy
);

    ser_state_t        state;
    logic [CODE_W-1:0] shreg;
    logic [LEN_W-1:0]  bits_left;

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [SYM_W-1:0] fifo_dout;
    logic             accept;
    logic             legal;
    logic             last_bit;

    assign sym_ready = !fifo_full;
    assign accept    = sym_valid && sym_ready;
    assign legal     = sym_is_legal(sym_in);
    assign last_bit  = (state == ST_SHIFT) && (bits_left == '0);
    assign fifo_pop  = !fifo_empty && ((state == ST_IDLE) || last_bit);

    sym_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (accept && legal),
        .push_data(sym_in),
        .pop      (fifo_pop),
        .pop_data (fifo_dout),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Serializer: a pop on the last bit reloads immediately so codes abut
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            bits_left <= '0;
            err       <= 1'b0;
        end else begin
            err <= accept && !legal;
            if (fifo_pop) begin
                state     <= ST_SHIFT;
                shreg     <= code_bits(fifo_dout);
                bits_left <= code_last(fifo_dout);
            end else if (last_bit) begin
                state     <= ST_IDLE;
                shreg     <= '0;
                bits_left <= '0;
            end else if (state == ST_SHIFT) begin
                shreg     <= {shreg[CODE_W-2:0], 1'b0};
                bits_left <= bits_left - LEN_W'(1);
            end
        end
    end

    assign x_valid = (state == ST_SHIFT);
    assign x       = x_valid && shreg[CODE_W-1];
    assign busy    = !fifo_empty || (state == ST_SHIFT);

endmodule

// File: tb/tb_huffman_encoder.sv
// Self-checking bench for huffman_encoder: queue-based reference model,
// per-cycle output compare, bit-stream decoder and directed scenarios.
module tb_huffman_encoder;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] sym_in = 3'd0;
    logic       sym_valid = 1'b0;
    logic       sym_ready;
    logic       x;
    logic       x_valid;
    logic       err;
    logic       busy;

    int checks = 0;
    int failures = 0;

    int  m_fifo[$];
    bit  m_bits[$];
    bit  m_err = 1'b0;

    int  acc_q[$];
    int  dec_q[$];
    int  dec_len = 0;
    int  dec_val = 0;
    int  err_cnt = 0;
    int  xv_cnt = 0;
    int  busy_cnt = 0;
    bit  ready_low_seen = 1'b0;

    string code_str[7] = '{"", "0", "101", "100", "111", "1101", "1100"};

    always #5 clk = ~clk;

    huffman_encoder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .sym_in   (sym_in),
        .sym_valid(sym_valid),
        .sym_ready(sym_ready),
        .x        (x),
        .x_valid  (x_valid),
        .err      (err),
        .busy     (busy)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] s, input logic v);
        @(posedge clk);
        #1;
        sym_in    = s;
        sym_valid = v;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle_timeout", busy, 0);
        @(posedge clk);
        #1;
    endtask

    // Reference model: a symbol queue plus the bit queue of the code on x
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_fifo.delete();
            m_bits.delete();
            m_err = 1'b0;
        end else begin
            bit acc;
            bit ok;
            int s;
            acc   = sym_valid && (m_fifo.size() < DEPTH);
            ok    = (sym_in >= 3'd1) && (sym_in <= 3'd6);
            m_err = acc && !ok;
            if (m_bits.size() <= 1) begin
                m_bits.delete();
                if (m_fifo.size() > 0) begin
                    s = m_fifo.pop_front();
                    for (int i = 0; i < code_str[s].len(); i++)
                        m_bits.push_back(code_str[s][i] == "1");
                end
            end else begin
                void'(m_bits.pop_front());
            end
            if (acc && ok) m_fifo.push_back(int'(sym_in));
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("x_valid", x_valid, int'(m_bits.size() > 0));
            checkOutput("x", x, (m_bits.size() > 0) ? int'(m_bits[0]) : 0);
            checkOutput("err", err, int'(m_err));
            checkOutput("busy", busy, int'(m_fifo.size() > 0 || m_bits.size() > 0));
            checkOutput("sym_ready", sym_ready, int'(m_fifo.size() < DEPTH));
        end
    end

    // Decodes the serial stream and logs accepted legal symbols
    always @(negedge clk or posedge reset) begin
        if (reset) begin
            acc_q.delete();
            dec_q.delete();
            dec_len = 0;
            dec_val = 0;
        end else begin
            if (err) err_cnt++;
            if (busy) busy_cnt++;
            if (!sym_ready) ready_low_seen = 1'b1;
            if (sym_valid && sym_ready && sym_in >= 3'd1 && sym_in <= 3'd6)
                acc_q.push_back(int'(sym_in));
            if (x_valid) begin
                int d;
                xv_cnt++;
                dec_val = dec_val * 2 + int'(x);
                dec_len++;
                d = -1;
                if (dec_len == 1 && dec_val == 0) d = 1;
                else if (dec_len == 3 && dec_val == 5) d = 2;
                else if (dec_len == 3 && dec_val == 4) d = 3;
                else if (dec_len == 3 && dec_val == 7) d = 4;
                else if (dec_len == 4 && dec_val == 13) d = 5;
                else if (dec_len == 4 && dec_val == 12) d = 6;
                else if (dec_len >= 4) d = 0;
                if (d >= 0) begin
                    dec_q.push_back(d);
                    dec_len = 0;
                    dec_val = 0;
                end
            end
        end
    end

    initial begin
        int stream;
        int vcnt;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_x", x, 0);
        checkOutput("rst_x_valid", x_valid, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_sym_ready", sym_ready, 1);
        reset = 1'b0;

        $display("[TB] single symbol 1");
        applyStimulus(3'd1, 1'b1);
        applyStimulus(3'd0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("sym1_x_valid", x_valid, 1);
        checkOutput("sym1_x", x, 0);
        @(posedge clk);
        #1;
        checkOutput("sym1_x_valid_end", x_valid, 0);
        checkOutput("sym1_busy_end", busy, 0);

        $display("[TB] back-to-back 2 then 5");
        waitIdle();
        applyStimulus(3'd2, 1'b1);
        applyStimulus(3'd5, 1'b1);
        applyStimulus(3'd0, 1'b0);
        stream = 0;
        vcnt = 0;
        for (int i = 0; i < 7; i++) begin
            stream = stream * 2 + int'(x);
            vcnt += int'(x_valid);
            @(posedge clk);
            #1;
        end
        checkOutput("seq25_stream", stream, 7'b1011101);
        checkOutput("seq25_valid_cycles", vcnt, 7);
        checkOutput("seq25_x_valid_after", x_valid, 0);

        $display("[TB] illegal symbols 0 and 7");
        waitIdle();
        err_cnt = 0;
        xv_cnt = 0;
        busy_cnt = 0;
        applyStimulus(3'd0, 1'b1);
        applyStimulus(3'd7, 1'b1);
        applyStimulus(3'd0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("illegal_err_pulses", err_cnt, 2);
        checkOutput("illegal_x_valid_cycles", xv_cnt, 0);
        checkOutput("illegal_busy_cycles", busy_cnt, 0);

        $display("[TB] back-pressure with symbol 6");
        waitIdle();
        acc_q.delete();
        dec_q.delete();
        ready_low_seen = 1'b0;
        for (int i = 0; i < 20; i++) applyStimulus(3'd6, 1'b1);
        applyStimulus(3'd0, 1'b0);
        waitIdle();
        checkOutput("bp_ready_dropped", int'(ready_low_seen), 1);
        checkOutput("bp_code_count", dec_q.size(), acc_q.size());
        for (int i = 0; i < dec_q.size(); i++)
            checkOutput("bp_symbol", dec_q[i], 6);

        $display("[TB] reset during symbol 5");
        waitIdle();
        applyStimulus(3'd5, 1'b1);
        applyStimulus(3'd1, 1'b1);
        applyStimulus(3'd1, 1'b1);
        applyStimulus(3'd0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("rst5_third_bit_valid", x_valid, 1);
        checkOutput("rst5_third_bit", x, 0);
        reset = 1'b1;
        #1;
        checkOutput("rst5_x", x, 0);
        checkOutput("rst5_x_valid", x_valid, 0);
        checkOutput("rst5_busy", busy, 0);
        checkOutput("rst5_sym_ready", sym_ready, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        xv_cnt = 0;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("rst5_no_output", xv_cnt, 0);
        checkOutput("rst5_busy_after", busy, 0);

        $display("[TB] loopback symbols 1..6");
        waitIdle();
        acc_q.delete();
        dec_q.delete();
        for (int s = 1; s <= 6; s++) applyStimulus(3'(s), 1'b1);
        applyStimulus(3'd0, 1'b0);
        waitIdle();
        checkOutput("loop_count", dec_q.size(), 6);
        for (int i = 0; i < 6; i++)
            checkOutput("loop_symbol", (i < dec_q.size()) ? dec_q[i] : -1, i + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/huffman_encoder.md
HUFFMAN_ENCODER -- requirements
Module: huffman_encoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of buffered input symbols (power of two, min 2).
REQ-002 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port sym_in  input  3  symbol to encode; legal values 1..6.
REQ-005 SHALL have port sym_valid  input  1  sym_in is valid this cycle.
REQ-006 SHALL have port sym_ready  output  1  the encoder accepts sym_in this cycle.
REQ-007 SHALL have port x  output  1  serial code bit, feeding the huffman decoder input.
REQ-008 SHALL have port x_valid  output  1  x carries a code bit this cycle.
REQ-009 SHALL have port err  output  1  one-cycle pulse: an illegal symbol was consumed.
REQ-010 SHALL have port busy  output  1  FIFO non-empty or serializer active.

Function
REQ-011 SHALL use the code table (MSB first): 1="0", 2="101", 3="100", 4="111", 5="1101", 6="1100".
REQ-012 SHALL accept a symbol on a rising edge where sym_valid and sym_ready are both 1.
REQ-013 SHALL drive sym_ready = !fifo_full, with no same-cycle pass-through when full.
REQ-014 SHALL consume illegal symbols 0 and 7 without pushing them, and pulse err for one cycle after the accepting edge.
REQ-015 SHALL have a serializer FSM with states IDLE and SHIFT, a 4-bit shift register and a 2-bit remaining-bit counter.
REQ-016 In IDLE with FIFO non-empty, SHALL pop, load the code and length, and enter SHIFT.
REQ-017 In SHIFT, SHALL present the code MSB on x with x_valid=1, then shift and decrement each cycle.
REQ-018 On the last bit in SHIFT, SHALL pop and load the next code if the FIFO is non-empty (no gap between codes), else return to IDLE.
REQ-019 SHALL give a latency of 2 cycles when idle and empty: accepted at edge N, loaded at edge N+1, first bit valid after edge N+1.
REQ-020 SHALL perform a simultaneous push and pop with the occupancy count unchanged; the pop reads the oldest entry.
REQ-021 SHALL let FIFO pointers wrap modulo FIFO_DEPTH, with a count width of clog2(FIFO_DEPTH)+1.
REQ-022 SHALL hold x=0 and x_valid=0 whenever no code bit is being presented.
REQ-023 SHALL never lose, duplicate or reorder accepted legal symbols.

Reset
REQ-024 On reset SHALL asynchronously clear FIFO pointers and count, force FSM=IDLE, and clear shift register and counter.
REQ-025 SHALL give reset output values x=0, x_valid=0, err=0, busy=0, sym_ready=1.
REQ-026 Reset mid-symbol SHALL abandon the partial code and discard all buffered symbols, with no further x_valid until new symbols are accepted.

Structure
REQ-027 SHALL place symbol constants, code table (bits, lengths) and state encoding in shared package huff_pkg, also used by the decoder bench.
REQ-028 SHALL implement the buffer as sub-module sym_fifo (parameter DEPTH, 3-bit data, push/pop/full/empty), with the serializer in the top module.

Verification
REQ-029 SHALL cover: reset, accept symbol 1 at edge N -> after edge N+1, x_valid=1 and x=0 for exactly 1 cycle, then x_valid=0, busy=0.
REQ-030 SHALL cover: accept 2 then 5 on consecutive edges -> contiguous 7-cycle x stream 1,0,1,1,1,0,1 with x_valid held 1.
REQ-031 SHALL cover: accept sym_in=0 and sym_in=7 -> one err pulse each, no x_valid, busy stays 0.
REQ-032 SHALL cover: hold sym_valid=1 with sym_in=6 for 20 cycles -> sym_ready drops when count=4 and reasserts the cycle after a pop; output is repeated 1,1,0,0 with no gaps; accepted count equals emitted codes.
REQ-033 SHALL cover: assert reset during the 3rd bit of symbol 5 with 2 symbols queued -> x=0, x_valid=0, busy=0, sym_ready=1 immediately; nothing emitted afterwards.
REQ-034 SHALL cover: loopback into huffman_decoder, encoding 1,2,3,4,5,6 -> decoder emits y pulses 1,2,3,4,5,6 in order.
